// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: bubble instruction, FSM encoding and the
// 5-bit major opcode map (instr[6:2]) also consumed by the control unit.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  function automatic logic [4:0] opcode_of(input logic [31:0] instr);
    return instr[6:2];
  endfunction

endpackage

// File: rtl/instr_skid_buf.sv
// Single-entry skid buffer holding a fetched word (and its PC) that decode
// could not accept; clear wins over load.
module instr_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register and one-entry skid buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects park the stage and raise Fetch_Misalign.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Rdata,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Pc,
  output logic        IF_ID_Valid,
  output logic [31:0] IF_ID_Pc,
  output logic [31:0] IF_ID_Instr,
  output logic [4:0]  IF_ID_Opcode,
  output logic        Fetch_Misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         if_id_valid_q, if_id_valid_d;
  logic [31:0]  if_id_pc_q, if_id_pc_d;
  logic [31:0]  if_id_instr_q, if_id_instr_d;
  logic         misalign_q, misalign_d;

  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_pc, skid_instr;
  logic         redirect_bad;
  logic [31:0]  redirect_target;

  // PC is kept word aligned even when a misaligned target traps
  assign redirect_target = {Redirect_Pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_bad = |Redirect_Pc[1:0];
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^Redirect_Pc[1:0];
  assign redirect_bad        = 1'b0;
`endif

  instr_skid_buf u_skid (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_pc    (pc_q),
    .load_instr (Imem_Rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    misalign_d    = misalign_q;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;

    if (Redirect) begin
      pc_d          = redirect_target;
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      skid_clear    = 1'b1;
      misalign_d    = redirect_bad;
      state_d       = redirect_bad ? ST_HOLD : ST_FETCH;
    end else if (misalign_q) begin
      state_d = ST_HOLD;  // parked until an aligned redirect arrives
    end else if (Flush) begin
      if (skid_valid || (state_q == ST_FETCH && Imem_Ready)) pc_d = pc_q + 32'd4;
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      skid_clear    = 1'b1;
      state_d       = ST_FETCH;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_FETCH;
        ST_FETCH: begin
          if (Imem_Ready && !Stall) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = pc_q;
            if_id_instr_d = Imem_Rdata;
            pc_d          = pc_q + 32'd4;
          end else if (Imem_Ready) begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end else if (!Stall) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
          end
        end
        ST_HOLD: begin
          if (!Stall) begin
            if_id_valid_d = skid_valid;
            if_id_pc_d    = skid_pc;
            if_id_instr_d = skid_valid ? skid_instr : NOP_INSTR;
            pc_d          = pc_q + 32'd4;
            skid_clear    = 1'b1;
            state_d       = ST_FETCH;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      misalign_q    <= misalign_d;
    end
  end

  assign Imem_Req       = (state_q == ST_FETCH);
  assign Imem_Addr      = pc_q;
  assign IF_ID_Valid    = if_id_valid_q;
  assign IF_ID_Pc       = if_id_pc_q;
  assign IF_ID_Instr    = if_id_instr_q;
  assign IF_ID_Opcode   = opcode_of(if_id_instr_q);
  assign Fetch_Misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the stage.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ready = 1'b0;
  logic [31:0] Imem_Rdata;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Redirect_Pc = 32'h0;
  logic        IF_ID_Valid;
  logic [31:0] IF_ID_Pc;
  logic [31:0] IF_ID_Instr;
  logic [4:0]  IF_ID_Opcode;
  logic        Fetch_Misalign;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model of the stage
  bit          m_boot, m_trap, m_v, m_park_v;
  logic [31:0] m_pc, m_ipc, m_instr, m_park_pc, m_park_instr;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ready(Imem_Ready), .Imem_Rdata(Imem_Rdata), .Stall(Stall),
    .Flush(Flush), .Redirect(Redirect), .Redirect_Pc(Redirect_Pc),
    .IF_ID_Valid(IF_ID_Valid), .IF_ID_Pc(IF_ID_Pc), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_Opcode(IF_ID_Opcode), .Fetch_Misalign(Fetch_Misalign)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign Imem_Rdata = Imem_Ready ? mem_word(Imem_Addr) : 32'hDEAD_BEEF;

  task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_trap = 1'b0; m_v = 1'b0; m_park_v = 1'b0;
    m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h0000_0013;
    m_park_pc = 32'h0; m_park_instr = 32'h0;
  endtask

  task automatic model_bubble();
    m_v = 1'b0;
    m_instr = 32'h0000_0013;
  endtask

  task automatic model_update();
    bit          fetching, bad;
    logic [31:0] tgt;
    fetching = !m_boot && !m_park_v && !m_trap;
    tgt = {Redirect_Pc[31:2], 2'b00};
    bad = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    bad = (Redirect_Pc[1:0] != 2'b00);
`endif
    if (Redirect) begin
      m_pc = tgt; model_bubble(); m_park_v = 1'b0; m_boot = 1'b0; m_trap = bad;
    end else if (m_trap) begin
      // parked: nothing moves
    end else if (Flush) begin
      if (m_park_v || (fetching && Imem_Ready)) m_pc = m_pc + 32'd4;
      model_bubble(); m_park_v = 1'b0; m_boot = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_park_v) begin
      if (!Stall) begin
        m_v = 1'b1; m_ipc = m_park_pc; m_instr = m_park_instr;
        m_park_v = 1'b0; m_pc = m_pc + 32'd4;
      end
    end else if (Imem_Ready) begin
      if (Stall) begin
        m_park_v = 1'b1; m_park_pc = m_pc; m_park_instr = mem_word(m_pc);
      end else begin
        m_v = 1'b1; m_ipc = m_pc; m_instr = mem_word(m_pc); m_pc = m_pc + 32'd4;
      end
    end else if (!Stall) begin
      model_bubble();
    end
  endtask

  // one compare process: every cycle, away from the active edge
  always @(negedge Clk) begin
    if (chk_en) begin
      logic [31:0] ins;
      ins = m_instr;
      expect_val("imem_req", {31'h0, Imem_Req}, {31'h0, (!m_boot && !m_park_v && !m_trap)});
      expect_val("imem_addr", Imem_Addr, m_pc);
      expect_val("if_id_valid", {31'h0, IF_ID_Valid}, {31'h0, m_v});
      expect_val("if_id_pc", IF_ID_Pc, m_ipc);
      expect_val("if_id_instr", IF_ID_Instr, m_instr);
      expect_val("if_id_opcode", {27'h0, IF_ID_Opcode}, {27'h0, ins[6:2]});
      expect_val("fetch_misalign", {31'h0, Fetch_Misalign}, {31'h0, m_trap});
    end
  end

  task automatic step(input bit rdy, input bit stl, input bit fl, input bit rd, input logic [31:0] rpc);
    Imem_Ready = rdy; Stall = stl; Flush = fl; Redirect = rd; Redirect_Pc = rpc;
    @(posedge Clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    model_reset();
    #1;
    expect_val("reset_req", {31'h0, Imem_Req}, 32'h0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    chk_en = 1'b1;
    @(posedge Clk); #1;
    do_reset();
    // reset state literals
    expect_val("rst_addr", Imem_Addr, 32'h0);
    expect_val("rst_valid", {31'h0, IF_ID_Valid}, 32'h0);
    expect_val("rst_pc", IF_ID_Pc, 32'h0);
    expect_val("rst_instr", IF_ID_Instr, 32'h0000_0013);
    expect_val("rst_misalign", {31'h0, Fetch_Misalign}, 32'h0);

    // streaming: 0,4,8
    step(1, 0, 0, 0, 0);
    expect_val("boot_req", {31'h0, Imem_Req}, 32'h1);
    expect_val("addr0", Imem_Addr, 32'h0);
    step(1, 0, 0, 0, 0);
    expect_val("addr4", Imem_Addr, 32'h4);
    expect_val("ifid_pc0", IF_ID_Pc, 32'h0);
    expect_val("ifid_v0", {31'h0, IF_ID_Valid}, 32'h1);
    step(1, 0, 0, 0, 0);
    expect_val("addr8", Imem_Addr, 32'h8);
    expect_val("ifid_pc4", IF_ID_Pc, 32'h4);

    // three wait states at PC=8
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      expect_val("bubble_valid", {31'h0, IF_ID_Valid}, 32'h0);
      expect_val("bubble_instr", IF_ID_Instr, 32'h0000_0013);
      expect_val("bubble_opcode", {27'h0, IF_ID_Opcode}, 32'h4);
      expect_val("bubble_addr", Imem_Addr, 32'h8);
    end
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_val("addr10", Imem_Addr, 32'h10);

    // stall at 0x10 -> hold
    step(1, 1, 0, 0, 0);
    expect_val("hold_req", {31'h0, Imem_Req}, 32'h0);
    expect_val("hold_ifid_pc", IF_ID_Pc, 32'hC);
    step(1, 1, 0, 0, 0);
    expect_val("hold_frozen", IF_ID_Pc, 32'hC);
    step(1, 0, 0, 0, 0);
    expect_val("release_pc", IF_ID_Pc, 32'h10);
    expect_val("release_instr", IF_ID_Instr, mem_word(32'h10));
    expect_val("release_addr", Imem_Addr, 32'h14);

    // redirect overrides stall
    step(1, 1, 0, 1, 32'h100);
    expect_val("redir_valid", {31'h0, IF_ID_Valid}, 32'h0);
    expect_val("redir_addr", Imem_Addr, 32'h100);

    // wrap
    step(1, 0, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0);
    expect_val("wrap_addr", Imem_Addr, 32'h0);
    expect_val("wrap_ifid_pc", IF_ID_Pc, 32'hFFFF_FFFC);

    // misaligned redirect
    step(1, 0, 0, 1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    expect_val("mis_flag", {31'h0, Fetch_Misalign}, 32'h1);
    expect_val("mis_req", {31'h0, Imem_Req}, 32'h0);
    step(1, 0, 0, 0, 0);
    expect_val("mis_sticky", {31'h0, Fetch_Misalign}, 32'h1);
`else
    expect_val("mis_addr", Imem_Addr, 32'h100);
    expect_val("mis_flag", {31'h0, Fetch_Misalign}, 32'h0);
`endif
    step(1, 0, 0, 1, 32'h200);
    expect_val("aligned_addr", Imem_Addr, 32'h200);

    // flush advances PC only when a word was returned
    step(1, 0, 1, 0, 0);
    expect_val("flush_addr", Imem_Addr, 32'h204);
    expect_val("flush_valid", {31'h0, IF_ID_Valid}, 32'h0);
    step(0, 0, 1, 0, 0);
    expect_val("flush_idle_addr", Imem_Addr, 32'h204);

    // randomized traffic, with occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                          : ($urandom & 32'h0000_03FF);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, rpc);
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
